// File: rtl/sram_hs.sv
// Single-port SRAM with a valid/ready request/response handshake and a fixed response latency.
// Optional out-of-range address flagging is enabled with `define SRAM_HS_ADDR_CHECK_EN.
module sram_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata
`ifdef SRAM_HS_ADDR_CHECK_EN
    ,
    output logic                resp_err
`endif
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int OFFSET_W = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rdata_q;
    logic [IDX_W-1:0]   word_idx;
    logic               in_range;
    logic               accept;
    logic               mem_we;
    logic               unused_addr;

    // Without the range check the index simply wraps modulo DEPTH.
    assign word_idx    = req_addr[OFFSET_W +: IDX_W];
    assign unused_addr = ^req_addr;
`ifdef SRAM_HS_ADDR_CHECK_EN
    assign in_range    = (req_addr >> OFFSET_W) < ADDR_W'(DEPTH);
`else
    assign in_range    = 1'b1;
`endif

    assign accept     = req_valid && req_ready;
    assign mem_we     = accept && req_wr && in_range;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;

    // Storage has no reset so committed data survives a mid-transaction reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (req_wstrb[b]) begin
                    mem[word_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter reaches zero on the same edge that moves WAIT into RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= (!req_wr && in_range) ? mem[word_idx] : '0;
        end
    end

`ifdef SRAM_HS_ADDR_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (accept) begin
            resp_err <= !in_range;
        end
    end
`endif

endmodule

// File: tb/tb_sram_hs.sv
// Testbench for sram_hs: directed vector table, handshake corner cases, reset behaviour,
// a LATENCY=1 instance, and randomized traffic against a word-array reference model.
module tb_sram_hs;

    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;

    logic        l1_req_valid, l1_req_ready, l1_req_wr;
    logic [31:0] l1_req_addr, l1_req_wdata;
    logic [3:0]  l1_req_wstrb;
    logic        l1_resp_valid, l1_resp_ready;
    logic [31:0] l1_resp_rdata;

`ifdef SRAM_HS_ADDR_CHECK_EN
    logic        resp_err, l1_resp_err;
`endif

    always #5 clock = ~clock;

    sram_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
`ifdef SRAM_HS_ADDR_CHECK_EN
        , .resp_err(resp_err)
`endif
    );

    sram_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_wr(l1_req_wr),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_wstrb(l1_req_wstrb),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready), .resp_rdata(l1_resp_rdata)
`ifdef SRAM_HS_ADDR_CHECK_EN
        , .resp_err(l1_resp_err)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [int];
    logic        lastErr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Counts cycles from the accept edge to resp_valid, optionally stalls, then completes the handshake.
    task automatic waitResp(input int hold, output logic [31:0] rdata, output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 20);
        if (!resp_valid) timeoutFail("resp_valid");
        repeat (hold) @(negedge clock);
        rdata = resp_rdata;
`ifdef SRAM_HS_ADDR_CHECK_EN
        lastErr = resp_err;
`else
        lastErr = 1'b0;
`endif
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int hold,
                                 output logic [31:0] rdata, output int lat);
        int budget = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        while (!req_ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (!req_ready) timeoutFail("req_ready");
        @(posedge clock);
        #1 req_valid = 1'b0;
        waitResp(hold, rdata, lat);
    endtask

    task automatic l1Transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic validNext);
        l1_req_valid = 1'b1;
        l1_req_wr    = wr;
        l1_req_addr  = addr;
        l1_req_wdata = wdata;
        l1_req_wstrb = 4'hF;
        checkOutput("l1_req_ready_idle", 32'(l1_req_ready), 32'd1);
        @(posedge clock);
        #1 l1_req_valid = 1'b0;
        @(negedge clock);
        validNext = l1_resp_valid;
        rdata     = l1_resp_rdata;
        l1_resp_ready = 1'b1;
        @(posedge clock);
        #1 l1_resp_ready = 1'b0;
        @(negedge clock);
        checkOutput("l1_resp_valid_after_hs", 32'(l1_resp_valid), 32'd0);
    endtask

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, cur, wd, ad;
        logic [3:0]  st;
        logic        wr, vn;
        int          lat, w;

        vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0});
        vecs.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD});
        vecs.push_back('{1'b1, 32'h24, 32'h0BADF00D, 4'hF, 32'h0});
        vecs.push_back('{1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 32'h0});
        vecs.push_back('{1'b0, 32'h24, 32'h0,        4'h0, 32'h0BADF00D});
        vecs.push_back('{1'b1, 32'h13, 32'h77000000, 4'h8, 32'h0});
        vecs.push_back('{1'b0, 32'h11, 32'h0,        4'h0, 32'h77ADBEEF});
        vecs.push_back('{1'b1, 32'h00, 32'h600DCAFE, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h600DCAFE});

        reset = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_wr = 1'b0; l1_req_addr = '0; l1_req_wdata = '0; l1_req_wstrb = '0;
        l1_resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_l1_req_ready", 32'(l1_req_ready), 32'd1);
`ifdef SRAM_HS_ADDR_CHECK_EN
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
`endif
        @(negedge clock);

        $display("[TB] directed vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, rd, lat);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("vec%0d_ready_after", i), 32'(req_ready), 32'd1);
        end

        $display("[TB] response back-pressure");
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
        @(posedge clock);
        #1;
        req_wr = 1'b1; req_wdata = 32'h5555AAAA; req_wstrb = 4'hF;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!resp_valid) checkOutput("bp_ready_in_wait", 32'(req_ready), 32'd0);
        end while (!resp_valid && lat < 20);
        checkOutput("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_valid_c%0d", i), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("bp_rdata_c%0d", i), resp_rdata, 32'h77ADBEEF);
            checkOutput($sformatf("bp_req_ready_c%0d", i), 32'(req_ready), 32'd0);
            if (i < 4) @(negedge clock);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        checkOutput("bp_idle_after_hs", 32'(req_ready), 32'd1);
        checkOutput("bp_valid_after_hs", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        waitResp(0, rd, lat);
        checkOutput("bp_pending_write_lat", 32'(lat), 32'd2);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, lat);
        checkOutput("bp_pending_write_data", rd, 32'h5555AAAA);

        $display("[TB] reset during WAIT and RESP");
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE0000; req_wstrb = 4'hF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rstw_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rstw_resp_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rstw_req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        checkOutput("rstw_no_resp", 32'(resp_valid), 32'd0);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, lat);
        checkOutput("rstw_committed", rd, 32'hCAFE0000);

        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h30;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rstr_valid_before", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstr_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rstr_resp_rdata", resp_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rstr_req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);

        $display("[TB] address beyond DEPTH");
        applyStimulus(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, lat);
`ifdef SRAM_HS_ADDR_CHECK_EN
        checkOutput("oob_read_rdata", rd, 32'h0);
        checkOutput("oob_read_err", 32'(lastErr), 32'd1);
        applyStimulus(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 0, rd, lat);
        checkOutput("oob_write_err", 32'(lastErr), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, lat);
        checkOutput("oob_write_suppressed", rd, 32'h600DCAFE);
        checkOutput("inrange_err", 32'(lastErr), 32'd0);
`else
        checkOutput("wrap_read_rdata", rd, 32'h600DCAFE);
        applyStimulus(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 0, rd, lat);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, lat);
        checkOutput("wrap_write_word0", rd, 32'hBAD0BAD0);
`endif

        $display("[TB] LATENCY=1 instance");
        l1Transact(1'b1, 32'h40, 32'h13579BDF, rd, vn);
        checkOutput("l1_write_valid_k1", 32'(vn), 32'd1);
        checkOutput("l1_write_rdata", rd, 32'h0);
        l1Transact(1'b0, 32'h40, 32'h0, rd, vn);
        checkOutput("l1_read_valid_k1", 32'(vn), 32'd1);
        checkOutput("l1_read_rdata", rd, 32'h13579BDF);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 8; i++) begin
            ad = 32'h800 + 32'(i * 4);
            wd = $urandom;
            applyStimulus(1'b1, ad, wd, 4'hF, 0, rd, lat);
            model[wordOf(ad)] = wd;
        end
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            ad = 32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            w  = wordOf(ad);
            applyStimulus(wr, ad, wd, st, $urandom_range(0, 3), rd, lat);
            checkOutput($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
            if (wr) begin
                checkOutput($sformatf("rnd%0d_wresp", n), rd, 32'h0);
                cur = model[w];
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
                end
                model[w] = cur;
            end else begin
                checkOutput($sformatf("rnd%0d_rdata", n), rd, model[w]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
